// File: rtl/gate_bist_pkg.sv
// Shared types, constants and golden model for the mux_gates BIST checker.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } gate_bist_state_e;

    localparam int GATE_W = 7;

    localparam int INV_B  = 6;
    localparam int AND_B  = 5;
    localparam int OR_B   = 4;
    localparam int NAND_B = 3;
    localparam int NOR_B  = 2;
    localparam int XOR_B  = 1;
    localparam int XNOR_B = 0;

    function automatic logic [GATE_W-1:0] gate_expected(input logic a, input logic b);
        logic [GATE_W-1:0] e;
        e         = '0;
        e[INV_B]  = ~a;
        e[AND_B]  = a & b;
        e[OR_B]   = a | b;
        e[NAND_B] = ~(a & b);
        e[NOR_B]  = ~(a | b);
        e[XOR_B]  = a ^ b;
        e[XNOR_B] = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/gate_bist_checker_pattern_gen.sv
// Stimulus source for the BIST: 4-bit LFSR (x^4+x^3+1), or a 2-bit up-counter
// when GATE_BIST_EXHAUSTIVE_EN is defined.
module gate_bist_pattern_gen #(
    parameter logic [3:0] LFSR_SEED = 4'b1001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       adv,
    output logic [1:0] ab
);
    import gate_bist_pkg::*;

`ifdef GATE_BIST_EXHAUSTIVE_EN
    logic [1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= 2'b00;
        end else if (adv) begin
            cnt <= cnt + 2'd1;
        end
    end

    assign ab = cnt;
`else
    // An all-zero seed would lock the LFSR up.
    localparam logic [3:0] SEED_EFF = (LFSR_SEED == 4'b0000) ? 4'b0001 : LFSR_SEED;

    logic [3:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr <= SEED_EFF;
        end else if (adv) begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign ab = lfsr[1:0];
`endif

endmodule

// File: rtl/gate_bist_checker.sv
// BIST engine for mux_gates: drives a/b, checks the seven gate outputs, counts
// mismatches and captures the first failure. Option: GATE_BIST_EXHAUSTIVE_EN.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int         NUM_VECTORS = 16,
    parameter int         CNT_W       = 8,
    parameter logic [3:0] LFSR_SEED   = 4'b1001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [6:0]       dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [1:0]       err_ab,
    output logic [6:0]       err_exp,
    output logic [6:0]       err_got
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] DRIVE = ST_DRIVE;
    localparam logic [1:0] CHECK = ST_CHECK;
    localparam logic [1:0] DONE  = ST_DONE;

    localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS - 1);

    logic [1:0]        state;
    logic [7:0]        vec_cnt;
    logic              first_err;
    logic [1:0]        pat_ab;
    logic              accept;
    logic [GATE_W-1:0] exp_vec;
    logic              mismatch;

    // start is only honoured between runs.
    assign accept   = start && (state == IDLE || state == DONE);
    assign exp_vec  = gate_expected(a, b);
    assign mismatch = (dut_out != exp_vec);

    gate_bist_pattern_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_pattern_gen (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .adv  (state == DRIVE),
        .ab   (pat_ab)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a         <= 1'b0;
            b         <= 1'b0;
            done      <= 1'b0;
            fail_cnt  <= '0;
            vec_cnt   <= '0;
            first_err <= 1'b0;
            err_ab    <= '0;
            err_exp   <= '0;
            err_got   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state     <= DRIVE;
                        done      <= 1'b0;
                        fail_cnt  <= '0;
                        vec_cnt   <= '0;
                        first_err <= 1'b0;
                        err_ab    <= '0;
                        err_exp   <= '0;
                        err_got   <= '0;
                    end
                end
                DRIVE: begin
                    a     <= pat_ab[1];
                    b     <= pat_ab[0];
                    state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (fail_cnt != '1) begin
                            fail_cnt <= fail_cnt + CNT_W'(1);
                        end
                        if (!first_err) begin
                            first_err <= 1'b1;
                            err_ab    <= {a, b};
                            err_exp   <= exp_vec;
                            err_got   <= dut_out;
                        end
                    end
                    vec_cnt <= vec_cnt + 8'd1;
                    if (vec_cnt < LAST_VEC) begin
                        state <= DRIVE;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == DRIVE) || (state == CHECK);
    assign pass = done && (fail_cnt == '0);

endmodule

// File: tb/tb_gate_bist_checker.sv
// Self-checking bench for gate_bist_checker: table of fault-injection runs plus
// directed reset, saturation, ignored-start and mid-run-reset sequences.
module tb_gate_bist_checker;

    localparam int NV     = 16;
    localparam int NV_SAT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] fault_mode = 2'd0;

    logic       a, b, busy, done, pass;
    logic [7:0] fail_cnt;
    logic [1:0] err_ab;
    logic [6:0] err_exp, err_got, dut_out;

    logic       s_a, s_b, s_busy, s_done, s_pass;
    logic [1:0] s_fail_cnt, s_err_ab;
    logic [6:0] s_err_exp, s_err_got;

    int n_checks = 0;
    int n_err    = 0;

    logic [1:0] seq    [NV];
    logic [1:0] ab_log [NV];
    logic [1:0] first_log [NV];
    int         ab_n;

    typedef struct {
        string      name;
        logic [1:0] fault;
        int         exp_fail;
        logic       exp_pass;
        logic [1:0] exp_ab;
        logic [6:0] exp_exp;
        logic [6:0] exp_got;
    } run_vec_t;

    run_vec_t runs [4];

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_gates(input logic ra, input logic rb);
        return {~ra, ra & rb, ra | rb, ~(ra & rb), ~(ra | rb), ra ^ rb, ~(ra ^ rb)};
    endfunction

    // 0: healthy, 1: z stuck-at-0, 2: t stuck-at-1, 3: all outputs stuck-at-0
    function automatic logic [6:0] inject(input logic [1:0] mode, input logic [6:0] good);
        case (mode)
            2'd1:    return good & 7'b1111110;
            2'd2:    return good | 7'b1000000;
            2'd3:    return 7'b0000000;
            default: return good;
        endcase
    endfunction

    always_comb dut_out = inject(fault_mode, ref_gates(a, b));

    gate_bist_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .err_ab(err_ab), .err_exp(err_exp), .err_got(err_got)
    );

    gate_bist_checker #(.NUM_VECTORS(NV_SAT), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .a(s_a), .b(s_b), .dut_out(7'b0000000),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fail_cnt(s_fail_cnt),
        .err_ab(s_err_ab), .err_exp(s_err_exp), .err_got(s_err_got)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic build_seq();
        logic [3:0] l;
        l = 4'b1001;
        for (int i = 0; i < NV; i++) begin
`ifdef GATE_BIST_EXHAUSTIVE_EN
            seq[i] = 2'(i);
`else
            seq[i] = l[1:0];
            l      = {l[2:0], l[3] ^ l[2]};
`endif
        end
    endtask

    function automatic run_vec_t score(input string name, input logic [1:0] mode);
        run_vec_t   r;
        logic [6:0] g, e;
        bit         seen;
        r.name = name; r.fault = mode; r.exp_fail = 0;
        r.exp_ab = 2'b00; r.exp_exp = '0; r.exp_got = '0;
        seen = 0;
        for (int i = 0; i < NV; i++) begin
            e = ref_gates(seq[i][1], seq[i][0]);
            g = inject(mode, e);
            if (g != e) begin
                r.exp_fail++;
                if (!seen) begin
                    seen = 1; r.exp_ab = seq[i]; r.exp_exp = e; r.exp_got = g;
                end
            end
        end
        r.exp_pass = (r.exp_fail == 0);
        return r;
    endfunction

    // Pulses start, then samples on falling edges until done or a cycle budget expires.
    task automatic do_run(input bit mid_start, output int busy_cycles, output int done_at);
        int n;
        busy_cycles = 0; done_at = -1; ab_n = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (n = 1; n <= 100; n++) begin
            if (busy) busy_cycles++;
            if (n % 2 == 0 && busy && ab_n < NV) begin
                ab_log[ab_n] = {a, b};
                ab_n++;
            end
            if (done) begin
                done_at = n;
                break;
            end
            start = (mid_start && n == 5);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_ab"}, {a, b}, 0);
        check({tag, "_fail_cnt"}, fail_cnt, 0);
        check({tag, "_err"}, {err_ab, err_exp, err_got}, 0);
        check({tag, "_sat_outs"}, {s_busy, s_done, s_pass, s_fail_cnt, s_err_ab, s_err_exp, s_err_got, s_a, s_b}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, da;
        build_seq();
        runs[0] = score("golden", 2'd0);
        runs[1] = score("stuck_z", 2'd1);
        runs[2] = score("stuck_t", 2'd2);
        runs[3] = score("all_zero", 2'd3);

        // Reset held two edges, with start asserted on the second.
        @(negedge clk) start = 1'b1;
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        check_idle_outputs("reset");

        for (int r = 0; r < 4; r++) begin
            fault_mode = runs[r].fault;
            do_run(1'b0, bc, da);
            check({runs[r].name, "_busy_cycles"}, bc, 2 * NV);
            check({runs[r].name, "_done_at"}, da, 2 * NV + 1);
            check({runs[r].name, "_fail_cnt"}, fail_cnt, runs[r].exp_fail);
            check({runs[r].name, "_pass"}, pass, runs[r].exp_pass);
            check({runs[r].name, "_err_ab"}, err_ab, runs[r].exp_ab);
            check({runs[r].name, "_err_exp"}, err_exp, runs[r].exp_exp);
            check({runs[r].name, "_err_got"}, err_got, runs[r].exp_got);
            for (int i = 0; i < NV; i++) begin
                check($sformatf("%s_ab%0d", runs[r].name, i), ab_log[i], seq[i]);
            end
            if (r == 0) begin
                for (int i = 0; i < NV; i++) first_log[i] = ab_log[i];
                // Narrow counter saturates; its first failure is the first vector.
                check("sat_done", s_done, 1);
                check("sat_fail_cnt", s_fail_cnt, 3);
                check("sat_pass", s_pass, 0);
                check("sat_err_ab", s_err_ab, seq[0]);
                check("sat_err_exp", s_err_exp, ref_gates(seq[0][1], seq[0][0]));
                check("sat_err_got", s_err_got, 0);
            end
        end

        // start during a run must be ignored: same timing, count not cleared.
        fault_mode = 2'd1;
        do_run(1'b1, bc, da);
        check("ignstart_done_at", da, 2 * NV + 1);
        check("ignstart_busy_cycles", bc, 2 * NV);
        check("ignstart_fail_cnt", fail_cnt, runs[1].exp_fail);

        // Reset on the 10th cycle of a run, then a clean restart.
        fault_mode = 2'd0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_idle_outputs("midrst");
        do_run(1'b0, bc, da);
        check("restart_busy_cycles", bc, 2 * NV);
        check("restart_done_at", da, 2 * NV + 1);
        check("restart_pass", pass, 1);
        for (int i = 0; i < NV; i++) begin
            check($sformatf("restart_ab%0d", i), ab_log[i], first_log[i]);
        end

        // done is held while idle.
        repeat (3) @(negedge clk);
        check("done_held", done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
